vga_timing_gen: RTL
===================

# vga_timing_gen

Pixel-clock timing generator for the 640x480@60 Hz VGA output. It produces the raster coordinates, active-video flag and per-frame strobe consumed by the pattern generators. It also closes the loop on their output: it registers the selected 6-bit RGB together with hsync/vsync so all three leave the chip aligned. It sits between the pattern mux and the output pins at the top level.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  pixel clock, 25.175 MHz nominal
- rst  in  1  reset; asynchronous, active-high
- rgb_in  in  6  combinational pixel colour from the pattern mux, {R1,G1,B1,R0,G0,B0}
- x  out  10  horizontal counter, 0..H_TOTAL-1
- y  out  10  vertical counter, 0..V_TOTAL-1
- active  out  1  high when x < H_ACTIVE and y < V_ACTIVE
- next_frame  out  1  one-cycle strobe, once per frame
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- rgb_out  out  6  registered pixel colour, forced to 0 outside active video

## Operation

- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- h_cnt increments every clk. At H_TOTAL-1 it wraps to 0, and v_cnt increments in the same cycle.
- v_cnt wraps from V_TOTAL-1 to 0 only when h_cnt also wraps.
- x = h_cnt and y = v_cnt, driven directly from the counter registers.
- active is decoded combinationally from the current counters.
- next_frame = (h_cnt == 0) && (v_cnt == V_ACTIVE).
  - This is a combinational decode, high for exactly one clock per frame.
  - It fires at the start of the first blanking line, so pattern state updates never tear the visible image.
- hsync_raw is asserted for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- vsync_raw is asserted for V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491, for whole lines.
- Output stage registers, all in the same cycle:
  - hsync ← hsync_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE
  - vsync ← the same rule applied to vsync_raw
  - rgb_out ← active ? rgb_in : 6'b0
- No handshake. The downstream pattern logic must present rgb_in combinationally within the same cycle as x/y.
- Reset values:
  - h_cnt = 0, v_cnt = 0
  - hsync = vsync = ~SYNC_ACTIVE (deasserted)
  - rgb_out = 0
  - next_frame is low during reset, because counter (0,0) is not a strobe point.
- Reset mid-frame: counters return to (0,0) immediately and asynchronously. The next frame starts from the top-left with no partial strobe.

## Timing

- x, y, active, next_frame: valid in the same cycle as the counter state (latency 0).
- hsync, vsync, rgb_out: latency 1 clock relative to the counter state they describe. Sync and colour therefore stay mutually aligned.
- With the counter at (x,y), rgb_out in the following cycle equals rgb_in sampled at (x,y).
- Line period: 800 clocks. Frame period: 420000 clocks.
- next_frame period: 420000 clocks.
- Widths:
  - Counter compare constants are 10-bit.
  - Every parameter sum must be < 1024; the implementation checks this at elaboration.

## Test plan

- Reset: hold rst high, then release.
  - Required: x=0, y=0, active=1, hsync=vsync=1, rgb_out=0.
  - First next_frame occurs exactly 480*800 = 384000 clocks after reset release.
- Line timing: count clocks between consecutive x wraps.
  - Required: 800 each.
  - hsync low for exactly 96 clocks, first low in the cycle after x=656, high again in the cycle after x=752.
- Frame timing:
  - next_frame pulses exactly once per 420000 clocks, each a single cycle.
  - vsync low for exactly 1600 clocks, starting the cycle after (x=0, y=490).
- Blanking: drive rgb_in=6'b111111 constantly.
  - rgb_out = 6'h3F only in the cycle after active=1.
  - rgb_out is 0 in the cycle after x=640 and in the cycle after any y≥480.
  - Total visible pixels per frame: 307200.
- Alignment: drive rgb_in = x[5:0].
  - Required: rgb_out in cycle n+1 equals x[5:0] from cycle n, throughout active video.
- Mid-frame reset: assert rst at (x=300, y=200) for 3 clocks.
  - Required: immediate return to reset values.
  - No next_frame during or after reset until 384000 clocks after release.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-clock raster timing for 640x480@60 VGA.
// Produces raster coordinates, an active-video flag and a per-frame strobe.
// hsync, vsync and rgb_out are registered together so they leave aligned.
module vga_timing_gen #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter bit SYNC_ACTIVE = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] rgb_in,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active,
   output logic       next_frame,
   output logic       hsync,
   output logic       vsync,
   output logic [5:0] rgb_out
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Every counter compare constant must fit the 10-bit counters.
   if (H_TOTAL >= 1024 || V_TOTAL >= 1024) begin : g_width_check
      $error("vga_timing_gen: timing totals must be below 1024");
   end

   localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
   localparam logic [9:0] H_MAX_C  = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_SYN0_C = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_SYN1_C = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
   localparam logic [9:0] V_MAX_C  = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_SYN0_C = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_SYN1_C = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic [5:0] rgb_out_q, rgb_out_d;
   logic       h_wrap;
   logic       hsync_raw;
   logic       vsync_raw;

   // Raster counters: h wraps every line, v advances only on an h wrap.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      h_cnt_d = h_cnt_q + 10'd1;
      v_cnt_d = v_cnt_q;
      h_wrap  = (h_cnt_q == H_MAX_C);
      if (h_wrap) begin
         h_cnt_d = 10'd0;
         v_cnt_d = (v_cnt_q == V_MAX_C) ? 10'd0 : v_cnt_q + 10'd1;
      end
   end

   // Latency-0 decodes of the current counter state.
   always_comb begin
      active     = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
      // Strobe at the start of the first blanking line so pattern updates never tear.
      next_frame = (h_cnt_q == 10'd0) && (v_cnt_q == V_ACT_C);
      hsync_raw  = (h_cnt_q >= H_SYN0_C) && (h_cnt_q < H_SYN1_C);
      vsync_raw  = (v_cnt_q >= V_SYN0_C) && (v_cnt_q < V_SYN1_C);
   end

   // Output stage next values: sync polarity applied, colour blanked outside active video.
   always_comb begin
      hsync_d   = hsync_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d   = vsync_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      rgb_out_d = active ? rgb_in : 6'b0;
   end

   // State and output registers; reset returns to top-left with syncs deasserted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
         h_cnt_q   <= 10'd0;
         v_cnt_q   <= 10'd0;
         hsync_q   <= ~SYNC_ACTIVE;
         vsync_q   <= ~SYNC_ACTIVE;
         rgb_out_q <= 6'b0;
      end else begin
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         rgb_out_q <= rgb_out_d;
      end
   end

   assign x       = h_cnt_q;
   assign y       = v_cnt_q;
   assign hsync   = hsync_q;
   assign vsync   = vsync_q;
   assign rgb_out = rgb_out_q;

endmodule
